// File: rtl/execute_mdu_stage_pkg.sv
// Shared encodings for the execute stage and its multiply/divide unit.
package execute_mdu_stage_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } mdu_state_e;

    // Any op that touches HI/LO or the iterator; 9-15 decode as plain ALU ops.
    function automatic logic is_mdu_op(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd8);
    endfunction

    function automatic logic is_muldiv_op(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd4);
    endfunction

    function automatic logic is_signed_op(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/execute_mdu_stage_mdu_iter.sv
// Iterative multiply/divide engine working on operand magnitudes.
// Latency: WIDTH iterations plus one sign-fix cycle after start.
// Backpressure: none; caller must not start while busy.
module mdu_iter
    import execute_mdu_stage_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    mdu_state_e         state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic               neg_res;
    logic               neg_rem;
    logic               div_r;

    logic               st_div;
    logic               take_sign;
    logic               neg_a;
    logic               neg_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     add_term;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod_fix;

    // Divide by zero skips sign handling so HI comes back as the raw dividend.
    always_comb begin
        st_div    = (op == MD_DIV) || (op == MD_DIVU);
        take_sign = is_signed_op(op) && !(st_div && (b == '0));
        neg_a     = take_sign && a[WIDTH-1];
        neg_b     = take_sign && b[WIDTH-1];
        mag_a     = neg_a ? -a : a;
        mag_b     = neg_b ? -b : b;
    end

    always_comb begin
        add_term  = acc[0] ? {1'b0, opnd} : '0;
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + add_term;
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opnd};
        div_diff  = div_shift - {1'b0, opnd};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            acc     <= '0;
            opnd    <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            div_r   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc     <= {{WIDTH{1'b0}}, mag_a};
                        opnd    <= mag_b;
                        neg_res <= neg_a ^ neg_b;
                        neg_rem <= neg_a;
                        div_r   <= st_div;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= st_div ? S_DIV : S_MUL;
                    end
                end
                S_MUL, S_DIV: begin
                    if (state == S_MUL) begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    end else begin
                        acc <= {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                                acc[WIDTH-2:0], div_ge};
                    end
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= S_FIX;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign done = (state == S_FIX);

    always_comb begin
        prod_fix = neg_res ? -acc : acc;
        if (div_r) begin
            lo = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            hi = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        end else begin
            lo = prod_fix[WIDTH-1:0];
            hi = prod_fix[2*WIDTH-1:WIDTH];
        end
    end

endmodule

// File: rtl/execute_mdu_stage.sv
// Execute stage: registers the EX/MEM slot and owns HI/LO plus the MDU.
// Latency: one cycle into the slot; MULT/DIV results land in HI/LO WIDTH+1 cycles later.
// Backpressure: stalls on a held slot, and stalls HI/LO users while the MDU iterates.
module execute_mdu_stage
    import execute_mdu_stage_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       md_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] alu_res_in,
    input  logic [WIDTH-1:0] ea_in,
    input  logic             ovf_in,
    input  logic [REG_W-1:0] dest_in,
    input  logic             we_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] ea,
    output logic [WIDTH-1:0] dm_in,
    output logic             ovf,
    output logic [REG_W-1:0] dest,
    output logic             we,
    output logic             mdu_busy
);
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] mdu_hi;
    logic [WIDTH-1:0] mdu_lo;
    logic             mdu_done;
    logic             fire;
    logic [WIDTH-1:0] res_nxt;
    logic             we_nxt;

    // Only HI/LO users wait on the MDU; ordinary ops slip past it.
    assign in_ready = (!out_valid || out_ready) && !(is_mdu_op(md_op) && mdu_busy);
    assign fire     = in_valid && in_ready;

    mdu_iter #(.WIDTH(WIDTH)) u_mdu (
        .clk   (clk),
        .rst_n (rst_n),
        .start (fire && is_muldiv_op(md_op)),
        .op    (md_op),
        .a     (a),
        .b     (b),
        .busy  (mdu_busy),
        .done  (mdu_done),
        .hi    (mdu_hi),
        .lo    (mdu_lo)
    );

    always_comb begin
        res_nxt = alu_res_in;
        we_nxt  = we_in;
        case (md_op)
            MD_MFHI: res_nxt = hi_q;
            MD_MFLO: res_nxt = lo_q;
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO: begin
                res_nxt = '0;
                we_nxt  = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            ea        <= '0;
            dm_in     <= '0;
            ovf       <= 1'b0;
            dest      <= '0;
            we        <= 1'b0;
        end else if (fire) begin
            out_valid <= 1'b1;
            result    <= res_nxt;
            ea        <= ea_in;
            dm_in     <= b;
            ovf       <= ovf_in;
            dest      <= dest_in;
            we        <= we_nxt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // MTHI/MTLO are interlocked against busy, so they never race the MDU write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (mdu_done) begin
            hi_q <= mdu_hi;
            lo_q <= mdu_lo;
        end else if (fire && (md_op == MD_MTHI)) begin
            hi_q <= a;
        end else if (fire && (md_op == MD_MTLO)) begin
            lo_q <= a;
        end
    end

endmodule

// File: tb/tb_execute_mdu_stage.sv
// Randomized and directed bench for execute_mdu_stage against an arithmetic HI/LO model.
module tb_execute_mdu_stage;
    import execute_mdu_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  md_op;
    logic [31:0] a, b, alu_res_in, ea_in;
    logic        ovf_in;
    logic [4:0]  dest_in;
    logic        we_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result, ea, dm_in;
    logic        ovf;
    logic [4:0]  dest;
    logic        we;
    logic        mdu_busy;

    int checks = 0;
    int errors = 0;
    logic [31:0] hi_m, lo_m;

    always #5 clk = ~clk;

    execute_mdu_stage #(.WIDTH(32), .REG_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .md_op      (md_op),
        .a          (a),
        .b          (b),
        .alu_res_in (alu_res_in),
        .ea_in      (ea_in),
        .ovf_in     (ovf_in),
        .dest_in    (dest_in),
        .we_in      (we_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .ea         (ea),
        .dm_in      (dm_in),
        .ovf        (ovf),
        .dest       (dest),
        .we         (we),
        .mdu_busy   (mdu_busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Architectural effect of one instruction on HI/LO.
    function automatic void model_exec(input logic [3:0] op, input logic [31:0] aa, input logic [31:0] bb);
        longint      sp;
        logic [63:0] up;
        int          ia, ib;
        case (op)
            4'd1: begin
                sp = longint'($signed(aa)) * longint'($signed(bb));
                {hi_m, lo_m} = sp;
            end
            4'd2: begin
                up = {32'b0, aa} * {32'b0, bb};
                {hi_m, lo_m} = up;
            end
            4'd3: begin
                if (bb == 32'h0) begin
                    lo_m = 32'hFFFF_FFFF; hi_m = aa;
                end else if (aa == 32'h8000_0000 && bb == 32'hFFFF_FFFF) begin
                    lo_m = 32'h8000_0000; hi_m = 32'h0;
                end else begin
                    ia = $signed(aa); ib = $signed(bb);
                    lo_m = ia / ib; hi_m = ia % ib;
                end
            end
            4'd4: begin
                if (bb == 32'h0) begin
                    lo_m = 32'hFFFF_FFFF; hi_m = aa;
                end else begin
                    lo_m = aa / bb; hi_m = aa % bb;
                end
            end
            4'd7: hi_m = aa;
            4'd8: lo_m = aa;
            default: ;
        endcase
    endfunction

    // Called at a negedge; presents one instruction, waits for acceptance, checks the slot.
    task automatic issue(input logic [3:0] op, input logic [31:0] aa, input logic [31:0] bb,
                         input logic [31:0] alu, input logic [31:0] eav, input logic ovfv,
                         input logic [4:0] dst, input logic wev, output int stalls);
        logic [31:0] exp_res;
        logic        exp_we;
        md_op = op; a = aa; b = bb; alu_res_in = alu; ea_in = eav;
        ovf_in = ovfv; dest_in = dst; we_in = wev; in_valid = 1'b1;
        stalls = 0;
        #1;
        while (!in_ready && stalls < 200) begin
            @(negedge clk); #1;
            stalls++;
        end
        if (!in_ready) begin
            check("issue_timeout", {63'b0, in_ready}, 64'd1);
            in_valid = 1'b0;
            return;
        end
        exp_res = alu; exp_we = wev;
        if (op == 4'd5) exp_res = hi_m;
        else if (op == 4'd6) exp_res = lo_m;
        else if (op >= 4'd1 && op <= 4'd8) begin exp_res = 32'h0; exp_we = 1'b0; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_exec(op, aa, bb);
        @(negedge clk);
        check("slot_valid", {63'b0, out_valid}, 64'd1);
        check("slot_result", {32'b0, result}, {32'b0, exp_res});
        check("slot_we", {63'b0, we}, {63'b0, exp_we});
        check("slot_ea_dm", {ea, dm_in}, {eav, bb});
        check("slot_ovf_dest", {58'b0, ovf, dest}, {58'b0, ovfv, dst});
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int st;
        int n;
        logic [3:0] rop;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        md_op = 4'd0; a = '0; b = '0; alu_res_in = '0; ea_in = '0;
        ovf_in = 1'b0; dest_in = '0; we_in = 1'b0;
        hi_m = '0; lo_m = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", {63'b0, out_valid}, 64'd0);
        check("rst_busy", {63'b0, mdu_busy}, 64'd0);
        check("rst_slot", {ea, result}, 64'd0);
        check("rst_misc", {57'b0, dm_in == 32'h0, ovf, we, dest}, {57'b0, 1'b1, 7'b0});
        rst_n = 1'b1;

        // MULTU max*max, busy duration, then read back
        issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h10, 1'b0, 5'd3, 1'b1, st);
        n = 0;
        while (mdu_busy && n < 100) begin @(negedge clk); n++; end
        check("busy_cycles", 64'(n), 64'd33);
        issue(4'd5, 0, 0, 0, 0, 1'b0, 5'd4, 1'b1, st);
        issue(4'd6, 0, 0, 0, 0, 1'b0, 5'd5, 1'b1, st);

        // MFHI right behind MULT must stall for the whole busy window
        issue(4'd1, 32'hFFFF_FFFD, 32'd7, 0, 0, 1'b0, 5'd0, 1'b0, st);
        issue(4'd5, 0, 0, 0, 0, 1'b0, 5'd6, 1'b1, st);
        check("mfhi_stall", 64'(st), 64'd33);
        issue(4'd6, 0, 0, 0, 0, 1'b0, 5'd7, 1'b1, st);

        issue(4'd3, 32'hFFFF_FFF9, 32'd2, 0, 0, 1'b0, 5'd0, 1'b0, st);
        issue(4'd6, 0, 0, 0, 0, 1'b0, 5'd8, 1'b1, st);
        issue(4'd5, 0, 0, 0, 0, 1'b0, 5'd9, 1'b1, st);
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1'b0, 5'd0, 1'b0, st);
        issue(4'd6, 0, 0, 0, 0, 1'b0, 5'd8, 1'b1, st);
        issue(4'd5, 0, 0, 0, 0, 1'b0, 5'd9, 1'b1, st);
        issue(4'd4, 32'd5, 32'd0, 0, 0, 1'b0, 5'd0, 1'b0, st);
        issue(4'd6, 0, 0, 0, 0, 1'b0, 5'd8, 1'b1, st);
        issue(4'd5, 0, 0, 0, 0, 1'b0, 5'd9, 1'b1, st);

        // ALU ops flow past a busy MULT
        issue(4'd1, 32'd1234, 32'hFFFF_0000, 0, 0, 1'b0, 5'd0, 1'b1, st);
        for (int i = 1; i <= 3; i++) begin
            issue(4'd0, 0, 32'(i), 32'(i), 32'h100, 1'b0, 5'(i), 1'b1, st);
            check("alu_no_stall", 64'(st), 64'd0);
        end
        check("busy_during_alu", {63'b0, mdu_busy}, 64'd1);
        issue(4'd6, 0, 0, 0, 0, 1'b0, 5'd10, 1'b1, st);

        // downstream backpressure freezes the slot
        issue(4'd0, 0, 32'h77, 32'hA5, 32'h200, 1'b1, 5'd11, 1'b1, st);
        out_ready = 1'b0;
        md_op = 4'd0; alu_res_in = 32'h5A; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_in_ready", {63'b0, in_ready}, 64'd0);
            check("bp_hold", {31'b0, out_valid, result}, {31'b0, 1'b1, 32'hA5});
            @(negedge clk);
        end
        out_ready = 1'b1;
        issue(4'd0, 0, 32'h88, 32'h5A, 32'h204, 1'b0, 5'd12, 1'b1, st);
        check("bp_release", 64'(st), 64'd0);
        @(negedge clk);
        check("slot_drain", {63'b0, out_valid}, 64'd0);

        // randomized instruction mix
        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            issue(rop, rand_val(), rand_val(), $urandom, $urandom, 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), st);
            if ($urandom_range(0, 2) == 0) begin
                issue(4'd5, 0, 0, 0, 0, 1'b0, 5'd1, 1'b1, st);
                issue(4'd6, 0, 0, 0, 0, 1'b0, 5'd2, 1'b1, st);
            end
        end

        // reset in the middle of a divide
        issue(4'd3, 32'd1000, 32'd7, 0, 0, 1'b0, 5'd0, 1'b0, st);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_busy", {63'b0, mdu_busy}, 64'd0);
        check("rst_mid_valid", {31'b0, out_valid, result}, 64'd0);
        hi_m = '0; lo_m = '0;
        issue(4'd6, 0, 0, 32'hDEAD, 0, 1'b0, 5'd13, 1'b1, st);
        issue(4'd5, 0, 0, 32'hBEEF, 0, 1'b0, 5'd14, 1'b1, st);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/execute_mdu_stage.md
Name: execute_mdu_stage

Overview:
Parametrised execute stage that registers the execute result into the EX/MEM slot using a valid/ready handshake. It adds an iterative multiply/divide unit with architectural HI/LO registers, covering MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO. The combinational ALU, shifter and EA adder stay upstream; their results arrive on the inputs. Non-MDU instructions keep flowing while the MDU iterates. MDU-dependent instructions are interlocked until it finishes.

Parameters:
WIDTH, 32, datapath width for a, b, results, HI and LO.
REG_W, 5, width of the destination register index.

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset; one clock; reset is synchronous and active-low
in_valid  in  1  upstream holds a decoded instruction
in_ready  out  1  stage accepts the instruction this cycle
md_op  in  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9-15 treated as NONE
a  in  WIDTH  rs operand
b  in  WIDTH  rt operand; also the store data
alu_res_in  in  WIDTH  ALU/shifter result selected upstream
ea_in  in  WIDTH  effective address
ovf_in  in  1  ALU overflow flag
dest_in  in  REG_W  destination register index
we_in  in  1  register writeback enable
out_valid  out  1  EX/MEM slot holds a valid instruction
out_ready  in  1  downstream consumes the slot
result  out  WIDTH  writeback value
ea  out  WIDTH  registered ea_in
dm_in  out  WIDTH  registered b
ovf  out  1  registered ovf_in
dest  out  REG_W  registered dest_in
we  out  1  registered writeback enable; forced 0 for MULT/DIV/MTHI/MTLO
mdu_busy  out  1  MDU iterating

Behaviour:
- Reset: out_valid=0; result, ea, dm_in, dest, HI and LO are 0; ovf=0, we=0, mdu_busy=0; FSM goes to IDLE. Reset aborts any operation in progress, with no partial HI/LO write.
- Acceptance: fire = in_valid & in_ready.
  - in_ready = (!out_valid | out_ready) & !(is_mdu_op & mdu_busy).
  - is_mdu_op is md_op in 1..8. mdu_busy is the registered value.
- On fire, the slot loads on the next edge. If no fire and out_ready=1, out_valid drops to 0. If out_ready=0, all outputs hold.
- Result mux:
  - NONE: alu_res_in.
  - MFHI: current HI. MFLO: current LO.
  - MULT, DIV, MTHI, MTLO: result = 0, we = 0.
- MTHI/MTLO write HI or LO from a on the fire edge.
- MULT/MULTU/DIV/DIVU on fire:
  - Latch operand magnitudes (signed ops only) and result signs.
  - Go to MUL or DIV and set mdu_busy=1.
  - The instruction itself retires through the slot immediately with we=0.
- FSM states and transitions:
  - IDLE: waits for a MULT/DIV fire.
  - MUL: WIDTH cycles of shift-add on the 2*WIDTH product.
  - DIV: WIDTH cycles of restoring division, one quotient bit per cycle.
  - FIX: one cycle. Applies signs, writes HI/LO, then returns to IDLE.
  - Timing: mdu_busy=1 for exactly WIDTH+1 cycles (33 at default).
- Signs:
  - Product is negated if the operand signs differ.
  - Quotient is negated if the operand signs differ; the remainder takes the dividend's sign.
  - Results are truncated to WIDTH.
- Divide by zero: LO = all ones, HI = a. No sign fix is applied.
- Signed MIN/-1: LO = MIN, HI = 0.
- Interlock ordering:
  - An MFHI/MFLO/MTHI/MTLO/MULT/DIV presented while busy is stalled.
  - It is accepted in the first cycle mdu_busy=0, which is the cycle after FIX, and sees the new HI/LO.
- Counter: log2(WIDTH)+1 bits, cleared on entry to MUL/DIV.

Decomposition:
- Shared package holds:
  - md_op encodings (MD_NONE..MD_MTLO).
  - FSM state encodings (S_IDLE, S_MUL, S_DIV, S_FIX).
- One natural sub-module, mdu_iter, contains the FSM, counter, magnitude datapath and sign fix. Its interface is start, op, a, b, busy, done, hi, lo.
- HI/LO registers and the slot register live in the top.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF, then MFHI, MFLO -> mdu_busy high 33 cycles; MFHI stalled until busy low; results 0xFFFFFFFE and 0x00000001.
- MULT a=-3 b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV a=-7 b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV a=0x80000000 b=0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU a=5 b=0 -> LO=0xFFFFFFFF, HI=5.
- ADD stream (alu_res_in=1,2,3, we=1) issued during a busy MULT -> accepted back-to-back with results 1,2,3; the MULT slot shows we=0.
- out_ready=0 for 4 cycles with out_valid=1 -> in_ready=0 and outputs frozen; out_ready=1 -> next instruction loads on the following edge.
- rst_n=0 at iteration 10 of a DIV -> next cycle mdu_busy=0, HI=LO=0, out_valid=0; a following MFLO returns 0.
